rr_route_arbiter: RTL and testbench
===================================

// Module: rr_route_arbiter
// PURPOSE
//  Round-robin arbiter between 4 input FIFOs (first-word fall-through) and 4 output FIFOs.
//  Each cycle: grants at most one input whose head word is routable.
//  The head word's dest field selects an output; the arbiter pops it and pushes it there one cycle later.
//  Output almost_full flags give back-pressure.
//  Sits between the ingress FIFO bank and the egress FIFO bank of the router datapath.
// PARAMETERS
//  DW     12  word width; dest = word[DW-1:DW-2], rest is payload passed unchanged
//  CW      8  width of each per-output push counter
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-low (0 = reset)
//  empty        in   4      empty flag of input FIFO i
//  fifo_out     in   4*DW   head word of input FIFO i, bits [DW*i+DW-1:DW*i], valid when !empty[i]
//  almost_full  in   4      almost-full flag of output FIFO j
//  pop          out  4      one-hot pop strobe to input FIFO i
//  push         out  4      one-hot push strobe to output FIFO j
//  data_out     out  DW     word written to the output FIFO flagged by push
//  state        out  2      00 IDLE, 01 ACTIVE, 10 BLOCKED
//  push_cnt     out  4*CW   count of words pushed to output j
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - pop=0, push=0, data_out=0, state=IDLE, push_cnt all 0, rr pointer=0.
//    - Reset mid-transfer discards the in-flight word: no push on the following cycle.
//  - Eligibility (combinational):
//    - elig[i] = !empty[i] && !almost_full[dest_i], where dest_i = fifo_out word i [DW-1:DW-2].
//  - Grant:
//    - Search starts at input ptr and wraps: ptr, ptr+1, ... mod 4. First elig[i] wins.
//    - Winner gets pop[i]=1 in the same cycle (combinational off registered ptr/state).
//    - Next posedge: ptr <= winner+1 mod 4. With no winner, ptr holds.
//  - Stage 2 (1-cycle latency):
//    - At the posedge where pop[i]=1, the arbiter registers word i and its dest.
//    - Next cycle: push[dest]=1 and data_out = registered word; push is registered.
//    - When nothing is in flight: push=0 and data_out holds its last value.
//    - Back-to-back grants give one push every cycle (full throughput).
//  - almost_full is sampled only at grant time.
//    - An in-flight word is always pushed, even if almost_full rises that cycle.
//    - Output FIFOs keep >=1 entry of margin below almost_full.
//  - Head-of-line: a blocked input is skipped; other inputs still get served.
//  - state (registered, updated each posedge):
//    - IDLE when all empty.
//    - ACTIVE when any elig.
//    - BLOCKED when some !empty but no elig.
//    - Transitions: IDLE->ACTIVE/BLOCKED as inputs fill, BLOCKED->ACTIVE when almost_full clears,
//      any->IDLE when all empty. Any transition is allowed in one cycle.
//  - push_cnt[j] increments by 1 on each push[j]; CW-bit wrap from 2^CW-1 to 0.
//  - Invariants:
//    - pop and push each one-hot or zero.
//    - pop never asserted to an input with empty=1.
// TESTING
//  1. Reset held low 2 cycles with all FIFOs non-empty -> pop=0, push=0, state=00, push_cnt=0.
//     After release, the first pop is pop=0001.
//  2. Only input 0 non-empty, heads 12'h296,12'h196,12'h425 (dests 0,0,1).
//     -> pop=0001 for 3 cycles; push=0001,0001,0010 lagging by 1 cycle; data_out matches in order.
//  3. All 4 inputs non-empty, distinct dests, no almost_full -> pop 0001,0010,0100,1000,0001 ...
//     Round-robin on consecutive cycles.
//  4. almost_full=0100, input 1 head dest 2, input 3 head dest 0 -> input 1 is never popped.
//     Input 3 is served. When input 3 empties, state=10; clear almost_full -> next cycle pop=0010, state=01.
//  5. almost_full[1] rises the same cycle push[1] is asserted for an in-flight word -> the push still occurs.
//     No new pop targets output 1.
//  6. 256 words to dest 3 with CW=8 -> push_cnt[3] returns to 0. Pulse reset mid-stream
//     -> no push the next cycle, all counters=0.

Source files
------------

// File: rtl/rr_route_arbiter.sv
// rr_route_arbiter: round-robin router between four first-word
// fall-through ingress FIFOs and four egress FIFOs.
//
// Ports
//   clk          single clock, all state on posedge
//   reset        synchronous, active-low
//   empty        empty flag of ingress FIFO i
//   fifo_out     head word of ingress FIFO i at [DW*i +: DW]
//   almost_full  almost-full flag of egress FIFO j
//   pop          one-hot pop strobe to the granted ingress FIFO
//   push         one-hot push strobe to egress FIFO j (registered)
//   data_out     word accompanying push
//   state        00 IDLE, 01 ACTIVE, 10 BLOCKED
//   push_cnt     per-egress push counters at [CW*j +: CW]
module rr_route_arbiter #(
    parameter int DW = 12,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      empty,
    input  logic [4*DW-1:0] fifo_out,
    input  logic [3:0]      almost_full,
    output logic [3:0]      pop,
    output logic [3:0]      push,
    output logic [DW-1:0]   data_out,
    output logic [1:0]      state,
    output logic [4*CW-1:0] push_cnt
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] ACTIVE  = 2'b01;
    localparam logic [1:0] BLOCKED = 2'b10;

    logic [1:0]    ptr_q;
    logic [1:0]    ptr_d;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [3:0]    push_q;
    logic [3:0]    push_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [DW-1:0] word [4];
    logic [1:0]    dest [4];
    logic [3:0]    elig;
    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic          gnt;

    // Split heads into words and destinations; an input is eligible
    // only when it holds a word whose target egress has room.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            word[i] = fifo_out[DW*i +: DW];
            dest[i] = word[i][DW-1:DW-2];
            elig[i] = !empty[i] && !almost_full[dest[i]];
        end
    end

    // Rotating priority search starting at ptr_q. Walking the offsets
    // from the far end back to zero leaves the nearest eligible input
    // as the final assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (elig[ptr_q + 2'(k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ptr_q + 2'(k);
            end
        end
    end

    // Suppress the grant while reset is held so no ingress word is
    // consumed by a transfer that reset is about to discard.
    assign gnt = gnt_vld && reset;

    // Stage-2 and pointer next-state.
    always_comb begin
        push_d = 4'b0000;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (gnt) begin
            push_d = 4'b0001 << dest[gnt_idx];
            data_d = word[gnt_idx];
            ptr_d  = gnt_idx + 2'd1;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            cnt_d[j] = cnt_q[j] + CW'(push_q[j]);
        end
    end

    // Status FSM: next-state decode from the current inputs.
    always_comb begin
        state_d = BLOCKED;
        if (&empty) begin
            state_d = IDLE;
        end else if (|elig) begin
            state_d = ACTIVE;
        end
    end

    // Status FSM: state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status FSM: outputs.
    always_comb begin
        state = state_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q  <= 2'd0;
            push_q <= 4'b0000;
            data_q <= '0;
            for (int j = 0; j < 4; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            push_q <= push_d;
            data_q <= data_d;
            for (int j = 0; j < 4; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    always_comb begin
        pop = 4'b0000;
        if (gnt) begin
            pop = 4'b0001 << gnt_idx;
        end
    end

    assign push     = push_q;
    assign data_out = data_q;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            push_cnt[CW*j +: CW] = cnt_q[j];
        end
    end

endmodule

// File: tb/tb_rr_route_arbiter.sv
// tb_rr_route_arbiter: directed and random stimulus for rr_route_arbiter
// against a queue-based reference model.
module tb_rr_route_arbiter;

    localparam int DW = 12;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic [3:0]      empty;
    logic [4*DW-1:0] fifo_out;
    logic [3:0]      af;
    logic [3:0]      pop;
    logic [3:0]      push;
    logic [DW-1:0]   data_out;
    logic [1:0]      state;
    logic [4*CW-1:0] push_cnt;

    rr_route_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk(clk),
        .reset(rst_n),
        .empty(empty),
        .fifo_out(fifo_out),
        .almost_full(af),
        .pop(pop),
        .push(push),
        .data_out(data_out),
        .state(state),
        .push_cnt(push_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] q [4][$];

    int          m_ptr = 0;
    logic [3:0]  m_push = 4'b0;
    logic [11:0] m_data = 12'h0;
    logic [1:0]  m_state = 2'b00;
    int          m_cnt [4] = '{0, 0, 0, 0};

    logic [3:0]  last_pop;
    logic [3:0]  last_push;
    logic [1:0]  last_state;
    logic [7:0]  last_cnt3;
    logic [15:0] pushlog [$];
    logic [3:0]  poplog [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            empty[i] = (q[i].size() == 0);
            fifo_out[12*i +: 12] = (q[i].size() != 0) ? q[i][0] : 12'h000;
        end
    endtask

    task automatic cycle();
        logic [3:0]  el;
        logic [11:0] h;
        logic [11:0] w;
        logic [1:0]  st;
        int          win;
        bit          any;
        @(negedge clk);
        el  = 4'b0;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0) begin
                any = 1'b1;
                h = q[i][0];
                if (!af[h[11:10]]) el[i] = 1'b1;
            end
        end
        st = !any ? 2'b00 : (el != 0) ? 2'b01 : 2'b10;
        win = -1;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && el[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            end
        end
        chk("pop", 32'(pop), 32'(win < 0 ? 0 : (1 << win)));
        chk("push", 32'(push), 32'(m_push));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("state", 32'(state), 32'(m_state));
        for (int j = 0; j < 4; j++) begin
            chk("push_cnt", 32'(push_cnt[8*j +: 8]), 32'(m_cnt[j]));
        end
        last_pop   = pop;
        last_push  = push;
        last_state = state;
        last_cnt3  = push_cnt[31:24];
        if (push != 0) pushlog.push_back({push, data_out});
        if (pop != 0) poplog.push_back(pop);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ptr   = 0;
            m_push  = 4'b0;
            m_data  = 12'h0;
            m_state = 2'b00;
            for (int j = 0; j < 4; j++) m_cnt[j] = 0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (m_push[j]) m_cnt[j] = (m_cnt[j] + 1) % 256;
            end
            if (win >= 0) begin
                w = q[win].pop_front();
                m_push = 4'(1 << w[11:10]);
                m_data = w;
                m_ptr  = (win + 1) % 4;
            end else begin
                m_push = 4'b0;
            end
            m_state = st;
        end
        drive();
    endtask

    task automatic drain(int extra);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0
               && n < 2000) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
        repeat (extra) cycle();
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        drive();
        cycle();
        rst_n = 1'b1;
        drive();
    endtask

    initial begin
        logic [11:0] w;
        rst_n = 1'b0;
        af    = 4'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].push_back({2'(i), 10'h11 * 10'(i + 1)});
            q[i].push_back({2'(3 - i), 10'h22 * 10'(i + 1)});
        end
        drive();

        // reset held two cycles with every input non-empty
        repeat (2) cycle();
        chk("t1_rst_pop", 32'(last_pop), 32'd0);
        chk("t1_rst_state", 32'(last_state), 32'd0);
        rst_n = 1'b1;
        drive();
        cycle();
        chk("t1_first_pop", 32'(last_pop), 32'b0001);
        drain(2);

        // single input, dests 0,0,1
        pushlog.delete();
        q[0].push_back(12'h296);
        q[0].push_back(12'h196);
        q[0].push_back(12'h425);
        drive();
        drain(2);
        chk("t2_npush", 32'(pushlog.size()), 32'd3);
        if (pushlog.size() == 3) begin
            chk("t2_push0", 32'(pushlog[0]), 32'h1296);
            chk("t2_push1", 32'(pushlog[1]), 32'h1196);
            chk("t2_push2", 32'(pushlog[2]), 32'h2425);
        end

        // all inputs busy, distinct dests
        rst_pulse();
        poplog.delete();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) q[i].push_back({2'(i), 10'(16 * i + k)});
        end
        drive();
        drain(2);
        chk("t3_npop", 32'(poplog.size()), 32'd12);
        for (int k = 0; k < poplog.size(); k++) begin
            chk("t3_rr", 32'(poplog[k]), 32'(1 << (k % 4)));
        end

        // head-of-line block on output 2
        af = 4'b0100;
        q[1].push_back(12'h8AA);
        q[1].push_back(12'h8BB);
        q[3].push_back(12'h0CC);
        q[3].push_back(12'h011);
        q[3].push_back(12'h022);
        drive();
        for (int n = 0; n < 20 && q[3].size() != 0; n++) cycle();
        repeat (2) cycle();
        chk("t4_q1_held", 32'(q[1].size()), 32'd2);
        chk("t4_q3_done", 32'(q[3].size()), 32'd0);
        chk("t4_blocked", 32'(last_state), 32'b10);
        af = 4'b0000;
        drive();
        cycle();
        chk("t4_pop1", 32'(last_pop), 32'b0010);
        cycle();
        chk("t4_active", 32'(last_state), 32'b01);
        drain(2);

        // almost_full rises while a word is in flight
        q[0].push_back(12'h4A1);
        q[0].push_back(12'h4A2);
        drive();
        cycle();
        af = 4'b0010;
        drive();
        cycle();
        chk("t5_push", 32'(last_push), 32'b0010);
        chk("t5_nopop", 32'(last_pop), 32'b0000);
        af = 4'b0000;
        drive();
        drain(2);

        // counter wrap, then reset mid-stream
        rst_pulse();
        for (int k = 0; k < 256; k++) q[2].push_back({2'b11, 10'(k)});
        drive();
        drain(2);
        chk("t6_wrap", 32'(last_cnt3), 32'd0);
        for (int k = 0; k < 10; k++) q[2].push_back({2'b11, 10'(k)});
        drive();
        repeat (3) cycle();
        rst_n = 1'b0;
        drive();
        cycle();
        rst_n = 1'b1;
        drive();
        cycle();
        chk("t6_rst_nopush", 32'(last_push), 32'd0);
        chk("t6_rst_cnt", 32'(last_cnt3), 32'd0);
        drain(2);

        // random traffic and back-pressure
        for (int n = 0; n < 400; n++) begin
            int i;
            i = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0 && q[i].size() < 8) begin
                w = 12'($urandom);
                q[i].push_back(w);
            end
            af = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            drive();
            cycle();
        end
        rst_n = 1'b1;
        af = 4'b0000;
        drive();
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
